// File: rtl/alu_pkg.sv
// Shared ALU datapath types: shifter FSM states and shift-direction encodings.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } shift_state_t;

  localparam logic SHIFT_RIGHT = 1'b0;
  localparam logic SHIFT_LEFT  = 1'b1;

endpackage

// File: rtl/shift_1_bit.sv
// Single-position logical shifter (zero fill); direction selects left or right.
module shift_1_bit
  import alu_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic         d,
  output logic [N-1:0] y
);

  // Left moves bits toward the MSB, right toward the LSB; the vacated bit is 0.
  always_comb begin
    y = '0;
    if (d == SHIFT_LEFT) begin
      y = {a[N-2:0], 1'b0};
    end else begin
      y = {1'b0, a[N-1:1]};
    end
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle logical shifter: latches an operand, then shifts one bit per clock
// through a single shift_1_bit stage until the requested amount is consumed.
//
// Handshake: start is a request sampled on the rising edge and is accepted only in
// IDLE or DONE (never in SHIFT, where it is dropped without queueing). busy is high
// for every SHIFT cycle. done is a one-cycle pulse marking y as valid; y then holds
// until the next accepted start. All outputs come straight from registers.
module shift_sequencer
  import alu_pkg::*;
#(
  parameter int N  = 8,
  parameter int SW = $clog2(N) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [N-1:0]  a,
  input  logic [SW-1:0] shamt,
  input  logic          d,
  output logic          busy,
  output logic          done,
  output logic [N-1:0]  y
);

  localparam logic [SW-1:0] N_AMT = SW'(N);

  shift_state_t  state, state_next;
  logic [SW-1:0] count, count_next;
  logic          dir, dir_next;
  logic [N-1:0]  sh_reg, sh_next;
  logic [N-1:0]  shifted;
  logic [SW-1:0] load_count;

  // Amounts beyond the operand width saturate: N shifts already clear everything.
  assign load_count = (shamt > N_AMT) ? N_AMT : shamt;

  shift_1_bit #(.N(N)) u_shift (
    .a (sh_reg),
    .d (dir),
    .y (shifted)
  );

  // Next-state logic: accept requests in IDLE/DONE, step the shifter in SHIFT.
  always_comb begin
    state_next = state;
    count_next = count;
    dir_next   = dir;
    sh_next    = sh_reg;
    case (state)
      IDLE, DONE: begin
        state_next = IDLE;
        if (start) begin
          sh_next    = a;
          dir_next   = d;
          count_next = load_count;
          state_next = (load_count == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        sh_next    = shifted;
        count_next = count - 1'b1;
        if (count == SW'(1)) begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, counter, direction and operand registers; reset discards any request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      count  <= '0;
      dir    <= SHIFT_RIGHT;
      sh_reg <= '0;
    end else begin
      state  <= state_next;
      count  <= count_next;
      dir    <= dir_next;
      sh_reg <= sh_next;
    end
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);
  assign y    = sh_reg;

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: directed cases plus randomized requests against a
// arithmetic reference model; latency, busy length and done pulse width are checked.
module tb_shift_sequencer;
  import alu_pkg::*;

  localparam int N  = 8;
  localparam int SW = $clog2(N) + 1;

  logic          clk;
  logic          rst;
  logic          start;
  logic [N-1:0]  a_in;
  logic [SW-1:0] shamt_in;
  logic          d_in;
  logic          busy;
  logic          done;
  logic [N-1:0]  y;

  int n_checks = 0;
  int n_pass   = 0;

  logic [N-1:0] exp_q[$];
  int           k_q[$];
  logic [N-1:0] last_y;

  shift_sequencer #(.N(N), .SW(SW)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a_in),
    .shamt (shamt_in),
    .d     (d_in),
    .busy  (busy),
    .done  (done),
    .y     (y)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Reference model: clamp the amount, shift in wide arithmetic, truncate to N bits.
  function automatic int clamp_k(input int sh);
    return (sh > N) ? N : sh;
  endfunction

  function automatic logic [N-1:0] model(input logic [N-1:0] a, input int sh, input bit left);
    longint unsigned v;
    int k;
    k = clamp_k(sh);
    v = longint'(a);
    if (left) v = v << k;
    else      v = v >> k;
    return N'(v & ((64'd1 << N) - 1));
  endfunction

  // Driver: raise start with operands at a falling edge and log the expectation.
  task automatic issue(input logic [N-1:0] a, input logic [SW-1:0] sh, input bit left);
    start    = 1'b1;
    a_in     = a;
    shamt_in = sh;
    d_in     = left;
    exp_q.push_back(model(a, int'(sh), left));
    k_q.push_back(clamp_k(int'(sh)));
  endtask

  // Collector: watch falling edges until done, optionally pulsing start mid-shift.
  task automatic collect(input int inject);
    int k, lat, nb;
    bit got;
    logic [N-1:0] exp;
    k   = k_q.pop_front();
    exp = exp_q.pop_front();
    lat = 0;
    nb  = 0;
    got = 1'b0;
    for (int c = 1; c <= N + 4 && !got; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == inject) begin
        start    = 1'b1;
        a_in     = '0;
        shamt_in = '0;
        d_in     = 1'b0;
      end
      if (busy) nb++;
      if (done) begin
        got = 1'b1;
        lat = c;
      end
    end
    check("latency", lat, k + 1);
    check("busy_cycles", nb, k);
    check("y_at_done", y, exp);
    last_y = exp;
  endtask

  // After a done with no new request: done must drop, y must hold, FSM idle.
  task automatic check_quiet();
    @(negedge clk);
    check("done_single_pulse", done, 0);
    check("busy_idle", busy, 0);
    check("y_hold", y, last_y);
  endtask

  initial begin
    logic [N-1:0] ra;
    logic [SW-1:0] rs;
    bit rd;

    rst      = 1'b1;
    start    = 1'b0;
    a_in     = '0;
    shamt_in = '0;
    d_in     = 1'b0;
    last_y   = '0;

    repeat (2) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_y", y, 0);
    check("reset_state", 32'(dut.state), 32'(IDLE));
    rst = 1'b0;
    @(negedge clk);

    // Directed: left by 3, right by 2, zero shift, saturating shifts.
    issue(8'hB5, 4'd3, 1'b1); collect(0); check_quiet();
    issue(8'hB5, 4'd2, 1'b0); collect(0); check_quiet();
    issue(8'h5A, 4'd0, 1'b1); collect(0); check_quiet();
    issue(8'hFF, 4'd8, 1'b1); collect(0); check_quiet();
    issue(8'hFF, 4'd15, 1'b0); collect(0); check_quiet();

    // start pulsed during SHIFT is dropped.
    issue(8'hB5, 4'd3, 1'b1); collect(1); check_quiet();
    issue(8'hC3, 4'd5, 1'b0); collect(4); check_quiet();

    // Back-to-back: new request accepted in the DONE cycle.
    issue(8'hB5, 4'd3, 1'b1); collect(0);
    issue(8'h96, 4'd1, 1'b0); collect(0);
    issue(8'h3C, 4'd0, 1'b1); collect(0); check_quiet();

    // Asynchronous reset in the middle of a shift.
    issue(8'hFF, 4'd6, 1'b1);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_done", done, 0);
    check("async_rst_y", y, 0);
    check("async_rst_state", 32'(dut.state), 32'(IDLE));
    void'(exp_q.pop_front());
    void'(k_q.pop_front());
    @(negedge clk);
    rst    = 1'b0;
    last_y = '0;
    check_quiet();
    issue(8'hA7, 4'd4, 1'b0); collect(0); check_quiet();

    // Randomized requests; roughly a quarter are chained back-to-back.
    for (int i = 0; i < 1000; i++) begin
      ra = N'($urandom_range(0, (1 << N) - 1));
      rs = SW'($urandom_range(0, (1 << SW) - 1));
      rd = 1'($urandom_range(0, 1));
      issue(ra, rs, rd);
      collect(0);
      if ($urandom_range(0, 3) != 0) check_quiet();
    end
    check_quiet();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
